// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer and the downstream single-bit FSM.
// Holds the 32-bit state width, the state constants, and a helper that
// sizes the bit counter.
package bit_serializer_pkg;

   localparam int STATE_W = 32;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE   = 32'd0,
      S_SHIFT  = 32'd1,
      S_PARITY = 32'd2
   } state_e;

   // Counter width for a WIDTH-bit frame; never below one bit.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel-in handshake and serial-out bundle of the bit serializer.
//   data_in/data_valid : word offered by the producer
//   data_ready         : serializer can take a word this cycle
//   a/a_valid          : serial bit and its qualifier for the downstream FSM
//   busy/done          : frame in flight / final-bit pulse
// master = producer/consumer side, slave = serializer side.
interface bit_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] data_in;
   logic             data_valid;
   logic             data_ready;
   logic             a;
   logic             a_valid;
   logic             busy;
   logic             done;

   modport master (
      output data_in, data_valid,
      input  data_ready, a, a_valid, busy, done
   );

   modport slave (
      input  data_in, data_valid,
      output data_ready, a, a_valid, busy, done
   );
endinterface

// File: rtl/bit_serializer.sv
// Bit serializer: accepts WIDTH-bit words over a valid/ready handshake and
// shifts them out MSB first, one bit per clock, on bus.a (qualified by
// bus.a_valid). Back-to-back frames reload on the last-bit cycle with no gap.
//
// Ports:
//   clock : system clock, rising edge
//   clear : synchronous active-high reset
//   bus   : bit_serializer_if.slave (data_in, data_valid, data_ready,
//           a, a_valid, busy, done)
//
// Build option: define SERIALIZER_PARITY_EN to append one even-parity bit
// (S_PARITY) after the data bits; done/data_ready then move to that cycle.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no frame; a = IDLE_BIT, ready for a word
// S_SHIFT  | sending data bit cnt_q; last bit when cnt_q == WIDTH-1
// S_PARITY | sending the parity bit (SERIALIZER_PARITY_EN only)
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int   WIDTH    = 8,
   parameter logic IDLE_BIT = 1'b0
) (
   input logic             clock,
   input logic             clear,
   bit_serializer_if.slave bus
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIALIZER_PARITY_EN
   logic             parity_q, parity_d;
`endif

   logic ser_bit, ser_valid, busy_c, done_c, ready_c, xfer;

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
`ifdef SERIALIZER_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
`ifdef SERIALIZER_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
`ifdef SERIALIZER_PARITY_EN
      parity_d  = parity_q;
`endif
      ser_bit   = IDLE_BIT;
      ser_valid = 1'b0;
      busy_c    = 1'b0;
      done_c    = 1'b0;
      ready_c   = 1'b0;
      xfer      = 1'b0;

      case (state_q)
         S_IDLE: begin
            ready_c = 1'b1;
         end
         S_SHIFT: begin
            ser_bit   = shift_q[WIDTH-1];
            ser_valid = 1'b1;
            busy_c    = 1'b1;
            shift_d   = {shift_q[WIDTH-2:0], 1'b0};
            cnt_d     = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cnt_d = '0;
`ifdef SERIALIZER_PARITY_EN
               state_d = S_PARITY;
`else
               done_c  = 1'b1;
               ready_c = 1'b1;
               state_d = S_IDLE;
`endif
            end
         end
`ifdef SERIALIZER_PARITY_EN
         S_PARITY: begin
            ser_bit   = parity_q;
            ser_valid = 1'b1;
            busy_c    = 1'b1;
            done_c    = 1'b1;
            ready_c   = 1'b1;
            state_d   = S_IDLE;
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Clear forces idle-looking outputs and blocks the handshake that cycle.
      if (clear) begin
         ser_bit   = IDLE_BIT;
         ser_valid = 1'b0;
         busy_c    = 1'b0;
         done_c    = 1'b0;
         ready_c   = 1'b0;
      end

      // ready_c is only high on idle or final-bit cycles, so a load here is
      // either a fresh start or a zero-bubble reload.
      xfer = bus.data_valid && ready_c;
      if (xfer) begin
         shift_d = bus.data_in;
         cnt_d   = '0;
         state_d = S_SHIFT;
`ifdef SERIALIZER_PARITY_EN
         parity_d = ^bus.data_in;
`endif
      end
   end

   assign bus.a          = ser_bit;
   assign bus.a_valid    = ser_valid;
   assign bus.busy       = busy_c;
   assign bus.done       = done_c;
   assign bus.data_ready = ready_c;

endmodule
